stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Sequencer that sits directly upstream of the stack pointer register and turns PUSH/POP/CALL/RET requests from the control unit into SP control codes and byte-wide stack-memory accesses. It owns the stack access order, bounds checking and multi-byte PC save/restore. The stack pointer value itself stays in the external SP register; this block reads it back and drives its 2-bit control input.

## Interface
- `n`, 8: data/SP width; memory is byte-wide.
- `SP_INIT`, 128: SP value after clear; empty-stack pointer.
- `SP_LIMIT`, 64: lowest usable SP; full-stack pointer.
- `clk` in 1: clock, rising edge for this block.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_op` in 2: 00 PUSH, 01 POP, 10 CALL, 11 RET.
- `req_data` in n: PUSH byte.
- `req_pc` in 2n: PC saved by CALL.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out 2n: POP byte zero-extended, or RET PC; 0 otherwise.
- `resp_err` out 1: bounds violation, valid with `resp_valid`.
- `sp_in` in n: current SP register value.
- `sp_ctrl` out 2: to SP register: 00 hold, 01 clear, 10 increment, 11 decrement.
- `mem_addr` out n, `mem_wdata` out n, `mem_we` out 1, `mem_re` out 1: stack memory port; synchronous read, data on `mem_rdata` one cycle after `mem_re`.
- `mem_rdata` in n: read data.

## Operation
- Stack grows downward; SP points at next free slot. Push: write at SP, then decrement. Pop: increment, then read at SP.
- Accept when `req_valid && req_ready`; `req_op`, `req_data`, `req_pc` are registered on accept.
- States: IDLE, WR, INC, RD, CAP, DONE; 1-bit byte counter for CALL/RET.
- PUSH: IDLE→WR→DONE. WR: `mem_addr=sp_in`, `mem_wdata`=byte, `mem_we=1`, `sp_ctrl=11`.
- CALL: IDLE→WR(pc[2n-1:n])→WR(pc[n-1:0])→DONE.
- POP: IDLE→INC→RD→CAP→DONE. INC: `sp_ctrl=10`. RD: `mem_addr=sp_in`, `mem_re=1`. CAP: latch `mem_rdata`.
- RET: INC→RD→CAP (low byte)→INC→RD→CAP (high byte)→DONE.
- DONE: `resp_valid=1` for one cycle, then IDLE.
- Bounds, checked on accept against `sp_in`: PUSH needs `sp_in > SP_LIMIT`; CALL needs `sp_in - SP_LIMIT >= 2`; POP needs `sp_in < SP_INIT`; RET needs `SP_INIT - sp_in >= 2`. On violation: IDLE→DONE directly with `resp_err=1`, `resp_data=0`; no memory access, `sp_ctrl=00`.
- `sp_ctrl=00`, `mem_we=0`, `mem_re=0` in every state not listed above.
- Reset (`rst_n` low at a rising edge): state→IDLE, all outputs 0 except `sp_ctrl=01` for every cycle `rst_n` is low. A reset mid-operation aborts it: no further writes, no `resp_valid`.

## Timing
- SP register updates on the falling edge. A `sp_ctrl` code driven in cycle k is reflected in `sp_in` at the rising edge ending cycle k, so the next state sees the new SP.
- Latency from accept edge to `resp_valid` high: PUSH 2, CALL 3, POP 4, RET 7, error 1.
- `req_ready` returns high the cycle after DONE. Back-to-back requests are spaced by at least one IDLE cycle.
- `resp_data`, `resp_err` are valid only while `resp_valid` is high.

## Configuration
- `STACK_CTRL_BOUNDS_CHECK_EN` defined: bounds checking as above.
- Not defined: no checks; `resp_err` tied 0; SP wraps modulo 2^n through the SP register.

## Structure
- Shared package `stack_pkg`: op encodings, SP control encodings (HOLD, CLEAR, INC, DEC), `SP_INIT` default, state enum.
- Single module, no sub-module. FSM, byte counter and capture register stay in this block.

## Test plan
- Reset, then PUSH 0xA5 with `sp_in=128` -> write addr 128 data 0xA5, `sp_ctrl=11` once, `resp_valid` 2 cycles after accept, `resp_err=0`.
- PUSH 0xA5 then POP -> INC, read addr 128, `resp_data=0x00A5` 4 cycles after accept, SP back to 128.
- CALL pc=0x1234 then RET -> writes 0x12@128, 0x34@127; RET returns `resp_data=0x1234` after 7 cycles, SP=128.
- POP at SP=128, and PUSH at SP=64 -> `resp_err=1` 1 cycle after accept, no `mem_we`/`mem_re`, `sp_ctrl` stays 00.
- Reset asserted during RET RD state -> no `resp_valid`, `sp_ctrl=01`, `req_ready=1` one cycle after reset release.
- Macro undefined: PUSH at SP=64 -> write performed, `resp_err=0`.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared encodings for the stack sequencer: request ops, SP register control codes,
// default stack bounds and the FSM state set.
package stack_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned SP_INIT_DEF  = 128;
  localparam int unsigned SP_LIMIT_DEF = 64;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SP_HOLD  = 2'b00,
    SP_CLEAR = 2'b01,
    SP_INC   = 2'b10,
    SP_DEC   = 2'b11
  } sp_ctrl_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_INC  = 3'd2,
    ST_RD   = 3'd3,
    ST_CAP  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Stack access sequencer: turns PUSH/POP/CALL/RET into SP control codes and byte-wide
// memory accesses. Bounds checking is compiled in with STACK_CTRL_BOUNDS_CHECK_EN.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned n        = DATA_W,
  parameter int unsigned SP_INIT  = SP_INIT_DEF,
  parameter int unsigned SP_LIMIT = SP_LIMIT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [n-1:0]   req_data,
  input  logic [2*n-1:0] req_pc,
  output logic           resp_valid,
  output logic [2*n-1:0] resp_data,
  output logic           resp_err,
  input  logic [n-1:0]   sp_in,
  output logic [1:0]     sp_ctrl,
  output logic [n-1:0]   mem_addr,
  output logic [n-1:0]   mem_wdata,
  output logic           mem_we,
  output logic           mem_re,
  input  logic [n-1:0]   mem_rdata
);

  state_e         state, state_nxt;
  op_e            op_q;
  logic [n-1:0]   data_q;
  logic [2*n-1:0] pc_q;
  logic [n-1:0]   sp_q;
  logic [n-1:0]   cap_lo, cap_hi;
  logic           cnt;
  logic           err_q;
  logic           err_c;

`ifdef STACK_CTRL_BOUNDS_CHECK_EN
  // Bounds check against the SP value seen at the accept edge.
  always_comb begin
    err_c = 1'b0;
    case (req_op)
      OP_PUSH: err_c = !(sp_in > n'(SP_LIMIT));
      OP_CALL: err_c = !({1'b0, sp_in} >= (n+1)'(SP_LIMIT + 2));
      OP_POP:  err_c = !(sp_in < n'(SP_INIT));
      OP_RET:  err_c = !(({1'b0, sp_in} + (n+1)'(2)) <= (n+1)'(SP_INIT));
      default: err_c = 1'b0;
    endcase
  end
`else
  assign err_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (err_c)                                   state_nxt = ST_DONE;
          else if (req_op == OP_PUSH || req_op == OP_CALL) state_nxt = ST_WR;
          else                                         state_nxt = ST_INC;
        end
      end
      ST_WR:   state_nxt = (op_q == OP_CALL && !cnt) ? ST_WR : ST_DONE;
      ST_INC:  state_nxt = ST_RD;
      ST_RD:   state_nxt = ST_CAP;
      ST_CAP:  state_nxt = (op_q == OP_RET && !cnt) ? ST_INC : ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, byte counter and read capture. The SP register moves on the falling
  // edge, so addresses use the SP value sampled at the opening edge of each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= OP_PUSH;
      data_q <= '0;
      pc_q   <= '0;
      sp_q   <= '0;
      cap_lo <= '0;
      cap_hi <= '0;
      cnt    <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sp_q <= sp_in;
      if (state == ST_IDLE && req_valid) begin
        op_q   <= op_e'(req_op);
        data_q <= req_data;
        pc_q   <= req_pc;
        err_q  <= err_c;
        cnt    <= 1'b0;
      end
      if (state == ST_WR) cnt <= ~cnt;
      if (state == ST_CAP) begin
        if (!cnt) cap_lo <= mem_rdata;
        else      cap_hi <= mem_rdata;
        cnt <= ~cnt;
      end
    end
  end

  // Output decode; reset forces the SP register to clear
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    sp_ctrl    = SP_HOLD;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    if (!rst_n) begin
      sp_ctrl = SP_CLEAR;
    end else begin
      case (state)
        ST_IDLE: req_ready = 1'b1;
        ST_WR: begin
          mem_addr  = sp_q;
          mem_we    = 1'b1;
          sp_ctrl   = SP_DEC;
          if (op_q == OP_CALL) mem_wdata = cnt ? pc_q[n-1:0] : pc_q[2*n-1:n];
          else                 mem_wdata = data_q;
        end
        ST_INC: sp_ctrl = SP_INC;
        ST_RD: begin
          mem_addr = sp_q;
          mem_re   = 1'b1;
        end
        ST_DONE: begin
          resp_valid = 1'b1;
          resp_err   = err_q;
          if (!err_q) begin
            if (op_q == OP_POP)      resp_data = {{n{1'b0}}, cap_lo};
            else if (op_q == OP_RET) resp_data = {cap_hi, cap_lo};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: models the falling-edge SP register and a synchronous-read
// byte memory, and scores each response against expectations queued at issue time.
module tb_stack_ctrl;
  import stack_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [7:0]  req_data = 8'h00;
  logic [15:0] req_pc = 16'h0000;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic [7:0]  sp;
  logic [1:0]  sp_ctrl;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  logic        sp_force = 1'b0;
  logic [7:0]  sp_force_val = 8'h00;
  logic [7:0]  mem [256];

  int we_cnt = 0, re_cnt = 0, inc_cnt = 0, dec_cnt = 0, rv_cnt = 0;
  int n_vec = 0, n_err = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_data   (req_data),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .sp_in      (sp),
    .sp_ctrl    (sp_ctrl),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  // Stack memory: write and synchronous read on the rising edge
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // SP register updates on the falling edge
  always @(negedge clk) begin
    if (sp_force) sp <= sp_force_val;
    else begin
      case (sp_ctrl)
        2'b01:   sp <= 8'd128;
        2'b10:   sp <= sp + 8'd1;
        2'b11:   sp <= sp - 8'd1;
        default: ;
      endcase
    end
  end

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    we_cnt  <= we_cnt + int'(mem_we);
    re_cnt  <= re_cnt + int'(mem_re);
    inc_cnt <= inc_cnt + int'(sp_ctrl == 2'b10);
    dec_cnt <= dec_cnt + int'(sp_ctrl == 2'b11);
    rv_cnt  <= rv_cnt + int'(resp_valid);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [15:0] pc);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
    end
    req_op = op; req_data = d; req_pc = pc; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output logic [15:0] d, output logic e);
    lat = 0; d = 16'h0000; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i; d = resp_data; e = resp_err;
        break;
      end
    end
  endtask

  task automatic force_sp(input logic [7:0] v);
    sp_force_val = v; sp_force = 1'b1;
    @(negedge clk);
    #1 sp_force = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (sp_ctrl !== 2'b01 || req_ready !== 1'b0 || resp_valid !== 1'b0 ||
        mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: sp_ctrl=%b ready=%b rv=%b we=%b re=%b addr=%h required 01 0 0 0 0 00",
               sp_ctrl, req_ready, resp_valid, mem_we, mem_re, mem_addr);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1 || sp_ctrl !== 2'b00 || sp !== 8'd128) begin
      n_err++;
      $display("FAIL reset_release: ready=%b sp_ctrl=%b sp=%0d required 1 00 128", req_ready, sp_ctrl, sp);
    end
  endtask

  task automatic test_push();
    int lat; logic [15:0] d; logic e; exp_t ex;
    int we0 = we_cnt, dec0 = dec_cnt, re0 = re_cnt, inc0 = inc_cnt;
    exp_q.push_back('{16'h0000, 1'b0, 2});
    issue(OP_PUSH, 8'hA5, 16'h0000);
    wait_resp(lat, d, e);
    ex = exp_q.pop_front();
    n_vec++;
    if (lat !== ex.lat || d !== ex.data || e !== ex.err) begin
      n_err++;
      $display("FAIL push_resp: lat=%0d data=%h err=%b required %0d %h %b", lat, d, e, ex.lat, ex.data, ex.err);
    end
    n_vec++;
    if (mem[128] !== 8'hA5 || sp !== 8'd127) begin
      n_err++;
      $display("FAIL push_mem_sp: mem[128]=%h sp=%0d required a5 127", mem[128], sp);
    end
    n_vec++;
    if (we_cnt - we0 != 1 || dec_cnt - dec0 != 1 || re_cnt - re0 != 0 || inc_cnt - inc0 != 0) begin
      n_err++;
      $display("FAIL push_ctrl: we=%0d dec=%0d re=%0d inc=%0d required 1 1 0 0",
               we_cnt - we0, dec_cnt - dec0, re_cnt - re0, inc_cnt - inc0);
    end
  endtask

  task automatic test_pop();
    int lat; logic [15:0] d; logic e; exp_t ex;
    int re0 = re_cnt, inc0 = inc_cnt, we0 = we_cnt;
    exp_q.push_back('{16'h00A5, 1'b0, 4});
    issue(OP_POP, 8'h00, 16'h0000);
    wait_resp(lat, d, e);
    ex = exp_q.pop_front();
    n_vec++;
    if (lat !== ex.lat || d !== ex.data || e !== ex.err) begin
      n_err++;
      $display("FAIL pop_resp: lat=%0d data=%h err=%b required %0d %h %b", lat, d, e, ex.lat, ex.data, ex.err);
    end
    n_vec++;
    if (sp !== 8'd128 || re_cnt - re0 != 1 || inc_cnt - inc0 != 1 || we_cnt - we0 != 0) begin
      n_err++;
      $display("FAIL pop_ctrl: sp=%0d re=%0d inc=%0d we=%0d required 128 1 1 0",
               sp, re_cnt - re0, inc_cnt - inc0, we_cnt - we0);
    end
  endtask

  task automatic test_call_ret();
    int lat; logic [15:0] d; logic e; exp_t ex;
    int we0 = we_cnt, dec0 = dec_cnt;
    exp_q.push_back('{16'h0000, 1'b0, 3});
    issue(OP_CALL, 8'h00, 16'h1234);
    wait_resp(lat, d, e);
    ex = exp_q.pop_front();
    n_vec++;
    if (lat !== ex.lat || d !== ex.data || e !== ex.err) begin
      n_err++;
      $display("FAIL call_resp: lat=%0d data=%h err=%b required %0d %h %b", lat, d, e, ex.lat, ex.data, ex.err);
    end
    n_vec++;
    if (mem[128] !== 8'h12 || mem[127] !== 8'h34 || sp !== 8'd126 ||
        we_cnt - we0 != 2 || dec_cnt - dec0 != 2) begin
      n_err++;
      $display("FAIL call_mem: m128=%h m127=%h sp=%0d we=%0d dec=%0d required 12 34 126 2 2",
               mem[128], mem[127], sp, we_cnt - we0, dec_cnt - dec0);
    end
    exp_q.push_back('{16'h1234, 1'b0, 7});
    issue(OP_RET, 8'h00, 16'h0000);
    wait_resp(lat, d, e);
    ex = exp_q.pop_front();
    n_vec++;
    if (lat !== ex.lat || d !== ex.data || e !== ex.err) begin
      n_err++;
      $display("FAIL ret_resp: lat=%0d data=%h err=%b required %0d %h %b", lat, d, e, ex.lat, ex.data, ex.err);
    end
    n_vec++;
    if (sp !== 8'd128) begin
      n_err++;
      $display("FAIL ret_sp: sp=%0d required 128", sp);
    end
  endtask

  task automatic test_bounds();
    int lat; logic [15:0] d; logic e; exp_t ex;
    int we0, re0, inc0, dec0;
`ifdef STACK_CTRL_BOUNDS_CHECK_EN
    logic [1:0] ops [4];
    logic [7:0] sps [4];
    ops[0] = OP_POP;  sps[0] = 8'd128;
    ops[1] = OP_PUSH; sps[1] = 8'd64;
    ops[2] = OP_CALL; sps[2] = 8'd65;
    ops[3] = OP_RET;  sps[3] = 8'd127;
    for (int i = 0; i < 4; i++) begin
      force_sp(sps[i]);
      we0 = we_cnt; re0 = re_cnt; inc0 = inc_cnt; dec0 = dec_cnt;
      exp_q.push_back('{16'h0000, 1'b1, 1});
      issue(ops[i], 8'h5A, 16'hFFFF);
      wait_resp(lat, d, e);
      ex = exp_q.pop_front();
      n_vec++;
      if (lat !== ex.lat || d !== ex.data || e !== ex.err) begin
        n_err++;
        $display("FAIL bounds_err_%0d: lat=%0d data=%h err=%b required %0d %h %b",
                 i, lat, d, e, ex.lat, ex.data, ex.err);
      end
      n_vec++;
      if (sp !== sps[i] || we_cnt != we0 || re_cnt != re0 || inc_cnt != inc0 || dec_cnt != dec0) begin
        n_err++;
        $display("FAIL bounds_quiet_%0d: sp=%0d we=%0d re=%0d inc=%0d dec=%0d required %0d 0 0 0 0",
                 i, sp, we_cnt - we0, re_cnt - re0, inc_cnt - inc0, dec_cnt - dec0, sps[i]);
      end
    end
    force_sp(8'd65);
    exp_q.push_back('{16'h0000, 1'b0, 2});
    issue(OP_PUSH, 8'h77, 16'h0000);
    wait_resp(lat, d, e);
    ex = exp_q.pop_front();
    n_vec++;
    if (lat !== ex.lat || e !== ex.err || mem[65] !== 8'h77 || sp !== 8'd64) begin
      n_err++;
      $display("FAIL bounds_edge_push: lat=%0d err=%b m65=%h sp=%0d required 2 0 77 64", lat, e, mem[65], sp);
    end
`else
    force_sp(8'd64);
    we0 = we_cnt; dec0 = dec_cnt; re0 = re_cnt; inc0 = inc_cnt;
    exp_q.push_back('{16'h0000, 1'b0, 2});
    issue(OP_PUSH, 8'h5A, 16'h0000);
    wait_resp(lat, d, e);
    ex = exp_q.pop_front();
    n_vec++;
    if (lat !== ex.lat || d !== ex.data || e !== ex.err) begin
      n_err++;
      $display("FAIL nocheck_push: lat=%0d data=%h err=%b required %0d %h %b", lat, d, e, ex.lat, ex.data, ex.err);
    end
    n_vec++;
    if (mem[64] !== 8'h5A || sp !== 8'd63 || we_cnt - we0 != 1 || dec_cnt - dec0 != 1) begin
      n_err++;
      $display("FAIL nocheck_mem: m64=%h sp=%0d we=%0d dec=%0d required 5a 63 1 1",
               mem[64], sp, we_cnt - we0, dec_cnt - dec0);
    end
    exp_q.push_back('{16'h005A, 1'b0, 4});
    issue(OP_POP, 8'h00, 16'h0000);
    wait_resp(lat, d, e);
    ex = exp_q.pop_front();
    n_vec++;
    if (lat !== ex.lat || d !== ex.data || e !== ex.err || sp !== 8'd64) begin
      n_err++;
      $display("FAIL nocheck_pop: lat=%0d data=%h err=%b sp=%0d required %0d %h %b 64",
               lat, d, e, sp, ex.lat, ex.data, ex.err);
    end
`endif
    force_sp(8'd128);
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [6];
    logic [7:0] vals [6];
    ops[0] = OP_PUSH; vals[0] = 8'h11;
    ops[1] = OP_PUSH; vals[1] = 8'h22;
    ops[2] = OP_PUSH; vals[2] = 8'h33;
    ops[3] = OP_POP;  vals[3] = 8'h00;
    ops[4] = OP_POP;  vals[4] = 8'h00;
    ops[5] = OP_POP;  vals[5] = 8'h00;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i < 3) exp_q.push_back('{16'h0000, 1'b0, 3});
          else       exp_q.push_back('{{8'h00, vals[5 - i]}, 1'b0, 5});
          issue(ops[i], vals[i], 16'h0000);
        end
      end
      begin
        for (int j = 0; j < 6; j++) begin
          int lat; logic [15:0] d; logic e; exp_t ex;
          wait_resp(lat, d, e);
          if (exp_q.size() == 0) ex = '{16'hxxxx, 1'bx, -1};
          else ex = exp_q.pop_front();
          n_vec++;
          if (d !== ex.data || e !== ex.err || (j > 0 && lat !== ex.lat)) begin
            n_err++;
            $display("FAIL b2b_%0d: lat=%0d data=%h err=%b required %0d %h %b", j, lat, d, e, ex.lat, ex.data, ex.err);
          end
        end
      end
    join
    n_vec++;
    if (sp !== 8'd128) begin
      n_err++;
      $display("FAIL b2b_sp: sp=%0d required 128", sp);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] d; logic e; exp_t ex;
    int rv0, we0;
    exp_q.push_back('{16'h0000, 1'b0, 3});
    issue(OP_CALL, 8'h00, 16'hBEEF);
    wait_resp(lat, d, e);
    ex = exp_q.pop_front();
    n_vec++;
    if (lat !== ex.lat || e !== ex.err) begin
      n_err++;
      $display("FAIL mid_call: lat=%0d err=%b required %0d %b", lat, e, ex.lat, ex.err);
    end
    issue(OP_RET, 8'h00, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (mem_re !== 1'b1 || mem_addr !== 8'd127) begin
      n_err++;
      $display("FAIL mid_rd_state: re=%b addr=%0d required 1 127", mem_re, mem_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    rv0 = rv_cnt; we0 = we_cnt;
    n_vec++;
    if (sp_ctrl !== 2'b01 || mem_re !== 1'b0 || resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_out: sp_ctrl=%b re=%b rv=%b required 01 0 0", sp_ctrl, mem_re, resp_valid);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1 || sp !== 8'd128) begin
      n_err++;
      $display("FAIL mid_release: ready=%b sp=%0d required 1 128", req_ready, sp);
    end
    repeat (6) @(negedge clk);
    n_vec++;
    if (rv_cnt != rv0 || we_cnt != we0) begin
      n_err++;
      $display("FAIL mid_abort: resp_valid=%0d writes=%0d required 0 0", rv_cnt - rv0, we_cnt - we0);
    end
    exp_q.push_back('{16'h0000, 1'b0, 2});
    issue(OP_PUSH, 8'hAB, 16'h0000);
    wait_resp(lat, d, e);
    ex = exp_q.pop_front();
    n_vec++;
    if (lat !== ex.lat || e !== ex.err || mem[128] !== 8'hAB || sp !== 8'd127) begin
      n_err++;
      $display("FAIL mid_resume: lat=%0d err=%b m128=%h sp=%0d required 2 0 ab 127", lat, e, mem[128], sp);
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_call_ret();
    test_bounds();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
